conv3x3_filter_engine: RTL and testbench
========================================

// Module: conv3x3_filter_engine
// PURPOSE
//  Downstream consumer of the 3x3 line-buffer window stage: accepts one 9-pixel window per valid cycle.
//  Applies a programmable signed 3x3 kernel (MAC), then rounds, shifts and saturates to an unsigned pixel.
//  Emits one filtered pixel per window at fixed latency, plus a per-line done pulse to the SoC wrapper.
//  No backpressure: the upstream stage cannot stall, so this block accepts a window every cycle.
// PARAMETERS
//  PIXEL_SIZE   8    unsigned pixel width, in bits
//  IMAGE_WIDTH  512  output pixels per line; o_line_done fires after this many outputs
//  COEF_WIDTH   8    signed two's-complement kernel coefficient width
// PORTS
//  clk           in   1             single clock; all logic on posedge
//  reset         in   1             synchronous, active-high reset
//  i_window      in   PIXEL_SIZE*9  window; tap k = i_window[k*PIXEL_SIZE +: PIXEL_SIZE], k = row*3 + col
//  i_window_vld  in   1             window valid
//  i_coef_wr     in   1             write shadow coefficient
//  i_coef_addr   in   4             shadow tap index, 0..8 (9..15 ignored)
//  i_coef_data   in   COEF_WIDTH    signed coefficient
//  i_shift       in   4             right-shift applied to the sum, 0..15; sampled with the commit
//  i_commit      in   1             request a shadow->active kernel copy
//  o_pixel       out  PIXEL_SIZE    filtered pixel
//  o_pixel_vld   out  1             o_pixel valid
//  o_line_done   out  1             one-cycle pulse with the IMAGE_WIDTH-th o_pixel_vld of a line
//  o_commit_busy out  1             commit is pending
// BEHAVIOUR
//  Reset values:
//   - outputs: o_pixel=0, o_pixel_vld=0, o_line_done=0, o_commit_busy=0.
//   - kernel: shadow and active kernels reset to identity (tap4=1, all others 0); active shift=0.
//   - state: pipeline valids and the line counter cleared.
//  Reset mid-line discards in-flight windows; no output is produced for them.
//  Pipeline, latency 4 (window on cycle N -> o_pixel_vld on cycle N+4):
//   S1: 9 products p_k = $signed({1'b0,pix_k}) * coef_k; width PIXEL_SIZE+COEF_WIDTH+1.
//   S2: three row partial sums, each widened by 2 bits.
//   S3: total sum, widened by 4 bits over the product width; no overflow is possible.
//   S4: if shift>0, add 1<<(shift-1) (round half up); arithmetic >>> shift.
//       Then clamp: <0 -> 0; >2^PIXEL_SIZE-1 -> 2^PIXEL_SIZE-1.
//  Valid propagates through a 4-bit shift register alongside the data.
//  Data registers hold their value when the stage valid is low.
//  Back-to-back windows produce back-to-back outputs.
//  Coefficient path:
//   - i_coef_wr writes shadow[i_coef_addr] on the same clock; addresses >8 are dropped.
//   - The active kernel never changes while any window is in S1..S4 or i_window_vld=1.
//   - Commit FSM, states IDLE and PEND:
//     - IDLE + i_commit: if the pipeline is empty and i_window_vld=0, copy shadow->active
//       and latch i_shift that cycle; stay in IDLE. Otherwise go to PEND, o_commit_busy=1.
//     - PEND: copy on the first cycle the pipeline is empty and i_window_vld=0, then go to IDLE
//       (o_commit_busy=0 from the next cycle). Further i_commit pulses in PEND are absorbed.
//     - i_coef_wr in the same cycle as the copy: the write lands in shadow after the copy
//       (it is not included in the copy).
//  Line counter:
//   - 0..IMAGE_WIDTH-1, increments on o_pixel_vld.
//   - At IMAGE_WIDTH-1 with o_pixel_vld: wraps to 0 and o_line_done=1 in that same cycle.
//   - o_line_done is registered with o_pixel.
// STRUCTURE
//  Package filter_pkg:
//   - localparams: PROD_W, SUM_W, TAPS=9, PIPE_LAT=4.
//   - IDENTITY_KERNEL constant and commit FSM state enum.
//  Sub-module conv3x3_mac_tree: S1..S3 multiply/add tree with valid shift, no control.
//  The top level holds the coefficient banks, commit FSM, S4 round/saturate and line counter.
// TESTING
//  1. Reset, identity kernel, windows with tap4=0..255 -> o_pixel = tap4 exactly 4 cycles later, vld contiguous.
//  2. Box blur:
//     - Load all coefs=1, shift=3, commit; all taps=200 -> sum 1800, +4, >>3 = 225.
//     - all taps=255 -> (2295+4)>>3 = 287, saturates to 255.
//  3. Laplacian: coefs 0,-1,0,-1,4,-1,0,-1,0, shift=0.
//     - center=10, others=50 -> -160, clamps to 0.
//     - center=100, others=10 -> 360, clamps to 255.
//  4. i_commit while a window stream is active:
//     - o_commit_busy=1; old kernel applied to every window already issued.
//     - copy on the first idle cycle; next window uses the new kernel.
//  5. IMAGE_WIDTH=8, 20 windows back-to-back -> o_line_done on outputs 8 and 16 only; counter = 4 at end.
//  6. Assert reset with 3 windows in flight -> no o_pixel_vld afterwards; kernel back to identity; counter 0.

Source files
------------

// File: rtl/conv3x3_filter_engine_pkg.sv
// Shared constants, widths and types for the 3x3 convolution filter engine.
package filter_pkg;

  localparam int TAPS       = 9;
  localparam int PIPE_LAT   = 4;
  localparam int CENTER_TAP = 4;

  // Default datapath widths (8-bit pixels, 8-bit signed coefficients).
  localparam int DEF_PIXEL_SIZE = 8;
  localparam int DEF_COEF_WIDTH = 8;

  // Product of a zero-extended pixel and a signed coefficient.
  function automatic int prod_width(input int pixel_size, input int coef_width);
    return pixel_size + coef_width + 1;
  endfunction

  // Nine products summed: 4 guard bits cover the worst case without overflow.
  function automatic int sum_width(input int pixel_size, input int coef_width);
    return prod_width(pixel_size, coef_width) + 4;
  endfunction

  localparam int PROD_W = DEF_PIXEL_SIZE + DEF_COEF_WIDTH + 1;
  localparam int SUM_W  = PROD_W + 4;

  // Taps whose coefficient is 1 in the identity kernel; all others are 0.
  localparam logic [TAPS-1:0] IDENTITY_KERNEL = 9'b0_0001_0000;

  typedef enum logic {
    COMMIT_IDLE = 1'b0,
    COMMIT_PEND = 1'b1
  } commit_state_e;

endpackage

// File: rtl/conv3x3_filter_engine_mac_tree.sv
// S1..S3 of the filter: nine signed products, three row sums, one total.
// Pure datapath with a valid shift register; no control of its own.
module conv3x3_mac_tree
  import filter_pkg::*;
#(
  parameter int PIXEL_SIZE = 8,
  parameter int COEF_WIDTH = 8
) (
  input  logic                                               clk,
  input  logic                                               reset,
  input  logic [PIXEL_SIZE*TAPS-1:0]                         i_window,
  input  logic                                               i_window_vld,
  input  logic [COEF_WIDTH*TAPS-1:0]                         i_coefs,
  output logic signed [sum_width(PIXEL_SIZE, COEF_WIDTH)-1:0] o_sum,
  output logic                                               o_sum_vld,
  output logic [2:0]                                         o_stage_vld
);

  localparam int PROD_L = prod_width(PIXEL_SIZE, COEF_WIDTH);
  localparam int ROW_L  = PROD_L + 2;
  localparam int SUM_L  = sum_width(PIXEL_SIZE, COEF_WIDTH);

  logic [PIXEL_SIZE-1:0]        pix  [TAPS];
  logic signed [COEF_WIDTH-1:0] coef [TAPS];

  logic signed [PROD_L-1:0] prod_q [TAPS];
  logic signed [PROD_L-1:0] prod_d [TAPS];
  logic signed [ROW_L-1:0]  row_q  [3];
  logic signed [ROW_L-1:0]  row_d  [3];
  logic signed [SUM_L-1:0]  sum_q;
  logic signed [SUM_L-1:0]  sum_d;
  logic [2:0]               vld_q;
  logic [2:0]               vld_d;

  generate
    for (genvar gi = 0; gi < TAPS; gi++) begin : g_unpack
      assign pix[gi]  = i_window[gi*PIXEL_SIZE +: PIXEL_SIZE];
      assign coef[gi] = i_coefs[gi*COEF_WIDTH +: COEF_WIDTH];
    end
  endgenerate

  // Next-state for all three stages; each stage holds its data when its input valid is low.
  always_comb begin
    for (int k = 0; k < TAPS; k++) begin
      prod_d[k] = i_window_vld ?
                  (PROD_L'($signed({1'b0, pix[k]})) * PROD_L'(coef[k])) : prod_q[k];
    end
    for (int r = 0; r < 3; r++) begin
      row_d[r] = vld_q[0] ?
                 (ROW_L'(prod_q[3*r]) + ROW_L'(prod_q[3*r+1]) + ROW_L'(prod_q[3*r+2])) :
                 row_q[r];
    end
    sum_d = vld_q[1] ? (SUM_L'(row_q[0]) + SUM_L'(row_q[1]) + SUM_L'(row_q[2])) : sum_q;
    vld_d = {vld_q[1:0], i_window_vld};
  end

  // Stage registers; reset drops every window in flight.
  always_ff @(posedge clk) begin
    if (reset) begin
      vld_q <= '0;
      sum_q <= '0;
      for (int k = 0; k < TAPS; k++) prod_q[k] <= '0;
      for (int r = 0; r < 3; r++)    row_q[r]  <= '0;
    end else begin
      vld_q <= vld_d;
      sum_q <= sum_d;
      for (int k = 0; k < TAPS; k++) prod_q[k] <= prod_d[k];
      for (int r = 0; r < 3; r++)    row_q[r]  <= row_d[r];
    end
  end

  assign o_sum       = sum_q;
  assign o_sum_vld   = vld_q[2];
  assign o_stage_vld = vld_q;

endmodule

// File: rtl/conv3x3_filter_engine.sv
// 3x3 programmable convolution: shadow/active kernel banks with a safe commit,
// MAC tree, round/shift/saturate output stage and a per-line done pulse.
module conv3x3_filter_engine
  import filter_pkg::*;
#(
  parameter int PIXEL_SIZE  = 8,
  parameter int IMAGE_WIDTH = 512,
  parameter int COEF_WIDTH  = 8
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic [PIXEL_SIZE*9-1:0]    i_window,
  input  logic                       i_window_vld,
  input  logic                       i_coef_wr,
  input  logic [3:0]                 i_coef_addr,
  input  logic [COEF_WIDTH-1:0]      i_coef_data,
  input  logic [3:0]                 i_shift,
  input  logic                       i_commit,
  output logic [PIXEL_SIZE-1:0]      o_pixel,
  output logic                       o_pixel_vld,
  output logic                       o_line_done,
  output logic                       o_commit_busy
);

  localparam int SUM_L = sum_width(PIXEL_SIZE, COEF_WIDTH);
  localparam int RND_L = SUM_L + 1;
  localparam int CNT_W = (IMAGE_WIDTH > 1) ? $clog2(IMAGE_WIDTH) : 1;
  localparam logic signed [RND_L-1:0] PIX_MAX = RND_L'((1 << PIXEL_SIZE) - 1);
  localparam logic [CNT_W-1:0]        CNT_LAST = CNT_W'(IMAGE_WIDTH - 1);

  // Kernel banks and commit control.
  logic signed [COEF_WIDTH-1:0] shadow_q [TAPS];
  logic signed [COEF_WIDTH-1:0] shadow_d [TAPS];
  logic signed [COEF_WIDTH-1:0] active_q [TAPS];
  logic signed [COEF_WIDTH-1:0] active_d [TAPS];
  logic [3:0]                   shift_q;
  logic [3:0]                   shift_d;
  commit_state_e                state_q;
  commit_state_e                state_d;
  logic                         copy_en;
  logic                         pipe_quiet;
  logic [COEF_WIDTH*TAPS-1:0]   active_flat;

  // MAC tree interface.
  logic signed [SUM_L-1:0] mac_sum;
  logic                    mac_vld;
  logic [2:0]              mac_stage_vld;

  // Output stage.
  logic signed [RND_L-1:0] sum_ext;
  logic signed [RND_L-1:0] round_inc;
  logic signed [RND_L-1:0] rounded;
  logic signed [RND_L-1:0] shifted;
  logic [PIXEL_SIZE-1:0]   clamped;
  logic [PIXEL_SIZE-1:0]   pixel_q;
  logic [PIXEL_SIZE-1:0]   pixel_d;
  logic                    pixel_vld_q;
  logic                    pixel_vld_d;
  logic                    line_done_q;
  logic                    line_done_d;
  logic [CNT_W-1:0]        line_cnt_q;
  logic [CNT_W-1:0]        line_cnt_d;

  // The kernel may only swap when no window is in S1..S4 and none is arriving.
  assign pipe_quiet = ~(|mac_stage_vld) & ~pixel_vld_q & ~i_window_vld;

  // Commit FSM: copy immediately when quiet, otherwise wait in PEND for the first quiet cycle.
  always_comb begin
    state_d = state_q;
    copy_en = 1'b0;
    case (state_q)
      COMMIT_IDLE: begin
        if (i_commit) begin
          if (pipe_quiet) copy_en = 1'b1;
          else            state_d = COMMIT_PEND;
        end
      end
      COMMIT_PEND: begin
        if (pipe_quiet) begin
          copy_en = 1'b1;
          state_d = COMMIT_IDLE;
        end
      end
      default: state_d = COMMIT_IDLE;
    endcase
  end

  // Kernel bank updates: the copy reads the old shadow, so a same-cycle write is not copied.
  always_comb begin
    shift_d = shift_q;
    for (int k = 0; k < TAPS; k++) begin
      shadow_d[k] = shadow_q[k];
      active_d[k] = active_q[k];
    end
    if (copy_en) begin
      shift_d = i_shift;
      for (int k = 0; k < TAPS; k++) active_d[k] = shadow_q[k];
    end
    for (int k = 0; k < TAPS; k++) begin
      if (i_coef_wr && (i_coef_addr == 4'(k))) shadow_d[k] = i_coef_data;
    end
  end

  // Control and kernel registers; both banks come out of reset as the identity kernel.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= COMMIT_IDLE;
      shift_q <= '0;
      for (int k = 0; k < TAPS; k++) begin
        shadow_q[k] <= IDENTITY_KERNEL[k] ? COEF_WIDTH'(1) : '0;
        active_q[k] <= IDENTITY_KERNEL[k] ? COEF_WIDTH'(1) : '0;
      end
    end else begin
      state_q <= state_d;
      shift_q <= shift_d;
      for (int k = 0; k < TAPS; k++) begin
        shadow_q[k] <= shadow_d[k];
        active_q[k] <= active_d[k];
      end
    end
  end

  // Flatten the active kernel for the MAC tree.
  always_comb begin
    active_flat = '0;
    for (int k = 0; k < TAPS; k++) active_flat[k*COEF_WIDTH +: COEF_WIDTH] = active_q[k];
  end

  conv3x3_mac_tree #(
    .PIXEL_SIZE (PIXEL_SIZE),
    .COEF_WIDTH (COEF_WIDTH)
  ) u_mac_tree (
    .clk          (clk),
    .reset        (reset),
    .i_window     (i_window),
    .i_window_vld (i_window_vld),
    .i_coefs      (active_flat),
    .o_sum        (mac_sum),
    .o_sum_vld    (mac_vld),
    .o_stage_vld  (mac_stage_vld)
  );

  // S4: round half up, arithmetic shift, clamp to the unsigned pixel range; count pixels per line.
  always_comb begin
    sum_ext   = RND_L'(mac_sum);
    round_inc = (shift_q != 4'd0) ? (RND_L'(1) << (shift_q - 4'd1)) : '0;
    rounded   = sum_ext + round_inc;
    shifted   = rounded >>> shift_q;
    if (shifted[RND_L-1])       clamped = '0;
    else if (shifted > PIX_MAX) clamped = '1;
    else                        clamped = shifted[PIXEL_SIZE-1:0];

    pixel_vld_d = mac_vld;
    pixel_d     = mac_vld ? clamped : pixel_q;
    line_done_d = mac_vld && (line_cnt_q == CNT_LAST);
    line_cnt_d  = line_cnt_q;
    if (mac_vld) line_cnt_d = (line_cnt_q == CNT_LAST) ? '0 : line_cnt_q + 1'b1;
  end

  // Output registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      pixel_q     <= '0;
      pixel_vld_q <= 1'b0;
      line_done_q <= 1'b0;
      line_cnt_q  <= '0;
    end else begin
      pixel_q     <= pixel_d;
      pixel_vld_q <= pixel_vld_d;
      line_done_q <= line_done_d;
      line_cnt_q  <= line_cnt_d;
    end
  end

  assign o_pixel       = pixel_q;
  assign o_pixel_vld   = pixel_vld_q;
  assign o_line_done   = line_done_q;
  assign o_commit_busy = (state_q == COMMIT_PEND);

endmodule

// File: tb/tb_conv3x3_filter_engine.sv
// Bench for conv3x3_filter_engine: random and directed windows against an arithmetic model.
module tb_conv3x3_filter_engine;

  localparam int PS = 8;
  localparam int IW = 8;
  localparam int CW = 8;

  logic            clk = 1'b0;
  logic            reset;
  logic [PS*9-1:0] i_window;
  logic            i_window_vld;
  logic            i_coef_wr;
  logic [3:0]      i_coef_addr;
  logic [CW-1:0]   i_coef_data;
  logic [3:0]      i_shift;
  logic            i_commit;
  logic [PS-1:0]   o_pixel;
  logic            o_pixel_vld;
  logic            o_line_done;
  logic            o_commit_busy;

  always #5 clk = ~clk;

  conv3x3_filter_engine #(
    .PIXEL_SIZE  (PS),
    .IMAGE_WIDTH (IW),
    .COEF_WIDTH  (CW)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .i_window      (i_window),
    .i_window_vld  (i_window_vld),
    .i_coef_wr     (i_coef_wr),
    .i_coef_addr   (i_coef_addr),
    .i_coef_data   (i_coef_data),
    .i_shift       (i_shift),
    .i_commit      (i_commit),
    .o_pixel       (o_pixel),
    .o_pixel_vld   (o_pixel_vld),
    .o_line_done   (o_line_done),
    .o_commit_busy (o_commit_busy)
  );

  typedef struct {
    int due;
    int pix;
  } exp_t;

  // Reference model state.
  int   shadow_m [9];
  int   active_m [9];
  int   shift_m;
  bit   pend_m;
  int   line_m;
  int   last_due;
  int   cyc;
  exp_t exp_q [$];
  int   tests;
  int   fails;

  task automatic check(input string tag, input logic [31:0] obs, input int expv);
    tests++;
    assert (obs === 32'(expv)) else begin
      fails++;
      $error("FAIL %s (cycle %0d): got %0d, expected %0d", tag, cyc, obs, expv);
    end
  endtask

  // Convolution with the model's active kernel, rounded, shifted and clamped.
  function automatic int ref_pixel(input logic [PS*9-1:0] w);
    int s = 0;
    for (int k = 0; k < 9; k++) s += int'(w[k*PS +: PS]) * active_m[k];
    if (shift_m > 0) s += 1 << (shift_m - 1);
    s = s >>> shift_m;
    if (s < 0)   s = 0;
    if (s > 255) s = 255;
    return s;
  endfunction

  function automatic logic [PS*9-1:0] rand_win();
    logic [PS*9-1:0] w;
    for (int k = 0; k < 9; k++) w[k*PS +: PS] = PS'($urandom_range(255));
    return w;
  endfunction

  task automatic model_reset();
    exp_q.delete();
    last_due = -100;
    shift_m  = 0;
    pend_m   = 0;
    line_m   = 0;
    for (int k = 0; k < 9; k++) begin
      shadow_m[k] = (k == 4) ? 1 : 0;
      active_m[k] = (k == 4) ? 1 : 0;
    end
  endtask

  task automatic drive_idle();
    i_window_vld = 1'b0;
    i_window     = '0;
    i_coef_wr    = 1'b0;
    i_coef_addr  = '0;
    i_coef_data  = '0;
    i_shift      = '0;
    i_commit     = 1'b0;
  endtask

  // Advance one clock and compare every output against the model.
  task automatic tick_check();
    bit exp_done;
    @(posedge clk);
    cyc++;
    #1;
    if (exp_q.size() > 0 && exp_q[0].due == cyc) begin
      check("pixel_vld", o_pixel_vld, 1);
      check("pixel", o_pixel, exp_q[0].pix);
      exp_done = (line_m == IW - 1);
      check("line_done", o_line_done, exp_done);
      line_m = exp_done ? 0 : line_m + 1;
      void'(exp_q.pop_front());
    end else begin
      check("pixel_vld_idle", o_pixel_vld, 0);
      check("line_done_idle", o_line_done, 0);
    end
    check("commit_busy", o_commit_busy, pend_m);
  endtask

  // One input cycle: drive, update the model by the commit/write rules, then clock and check.
  task automatic step(input bit wv, input logic [PS*9-1:0] w, input bit cwr, input int caddr,
                      input int cdata, input bit cmt, input int sh);
    bit quiet;
    quiet        = !(last_due >= cyc) && !wv;
    i_window_vld = wv;
    i_window     = w;
    i_coef_wr    = cwr;
    i_coef_addr  = 4'(caddr);
    i_coef_data  = CW'(cdata);
    i_commit     = cmt;
    i_shift      = 4'(sh);
    if (wv) begin
      exp_q.push_back('{cyc + 4, ref_pixel(w)});
      last_due = cyc + 4;
    end
    if ((pend_m || cmt) && quiet) begin
      active_m = shadow_m;
      shift_m  = sh;
      pend_m   = 0;
    end else if (cmt) begin
      pend_m = 1;
    end
    if (cwr && caddr < 9) shadow_m[caddr] = cdata;
    tick_check();
    drive_idle();
  endtask

  task automatic win(input logic [PS*9-1:0] w);
    step(1'b1, w, 1'b0, 0, 0, 1'b0, 0);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, '0, 1'b0, 0, 0, 1'b0, 0);
  endtask

  task automatic wr(input int addr, input int data);
    step(1'b0, '0, 1'b1, addr, data, 1'b0, 0);
  endtask

  task automatic commit(input int sh);
    step(1'b0, '0, 1'b0, 0, 0, 1'b1, sh);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    drive_idle();
    @(posedge clk);
    cyc++;
    #1;
    model_reset();
    reset = 1'b0;
    check("rst_pixel", o_pixel, 0);
    check("rst_pixel_vld", o_pixel_vld, 0);
    check("rst_line_done", o_line_done, 0);
    check("rst_commit_busy", o_commit_busy, 0);
  endtask

  initial begin
    logic [PS*9-1:0] w;
    int lap [9];
    lap   = '{0, -1, 0, -1, 4, -1, 0, -1, 0};
    tests = 0;
    fails = 0;
    cyc   = 0;
    reset = 1'b1;
    drive_idle();
    model_reset();

    // 1. Identity kernel out of reset: centre tap sweeps 0..255, other taps random.
    do_reset();
    for (int i = 0; i < 256; i++) begin
      w = rand_win();
      w[4*PS +: PS] = PS'(i);
      win(w);
    end
    idle(6);

    // 2. Box blur, shift 3: exact value and saturation.
    for (int k = 0; k < 9; k++) wr(k, 1);
    commit(3);
    win({9{8'd200}});
    win({9{8'd255}});
    for (int i = 0; i < 20; i++) win(rand_win());
    idle(6);

    // 3. Laplacian, shift 0: negative clamp and positive clamp.
    for (int k = 0; k < 9; k++) wr(k, lap[k]);
    commit(0);
    w = {9{8'd50}};
    w[4*PS +: PS] = 8'd10;
    win(w);
    w = {9{8'd10}};
    w[4*PS +: PS] = 8'd100;
    win(w);
    for (int i = 0; i < 20; i++) win(rand_win());
    idle(6);

    // 4. Commit during a stream is deferred; a second pulse is absorbed.
    for (int k = 0; k < 9; k++) wr(k, int'($urandom_range(255)) - 128);
    for (int i = 0; i < 10; i++)
      step(1'b1, rand_win(), 1'b0, 0, 0, (i == 5) || (i == 7), 2);
    idle(6);
    for (int i = 0; i < 10; i++) win(rand_win());
    idle(5);
    // Write coinciding with an immediate copy is not part of the copy.
    step(1'b0, '0, 1'b1, 0, 77, 1'b1, 1);
    for (int i = 0; i < 6; i++) win(rand_win());
    idle(5);
    wr(12, 5);
    commit(1);
    for (int i = 0; i < 6; i++) win(rand_win());
    idle(6);

    // 5. Line counter: 20 back-to-back outputs, then 4 more to land on the next line end.
    do_reset();
    for (int i = 0; i < 20; i++) win(rand_win());
    idle(6);
    for (int i = 0; i < 4; i++) win(rand_win());
    idle(6);

    // 6. Reset with windows in flight: nothing emerges, kernel and counter restart.
    for (int k = 0; k < 9; k++) wr(k, 3);
    commit(1);
    for (int i = 0; i < 3; i++) win(rand_win());
    do_reset();
    idle(6);
    commit(0);
    for (int i = 0; i < 8; i++) win(rand_win());
    idle(6);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
